// File: rtl/root_uplink_arbiter_if.sv
// Leaf-to-root channel bundle: NUM_LEAVES valid/ready inputs and one tagged output.
interface root_uplink_arbiter_if #(
  parameter int NUM_LEAVES    = 4,
  parameter int CHANNEL_WIDTH = 64,
  parameter int SRC_WIDTH     = 4
);
  logic [CHANNEL_WIDTH*NUM_LEAVES-1:0] in_data;
  logic [NUM_LEAVES-1:0]               in_valid;
  logic [NUM_LEAVES-1:0]               in_ready;
  logic [CHANNEL_WIDTH-1:0]            out_data;
  logic                                out_valid;
  logic                                out_ready;
  logic [SRC_WIDTH-1:0]                out_src;

  // Arbiter side: consumes leaf words, produces the root-bound stream.
  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

  // Environment side: leaves and the root consumer.
  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/root_uplink_arbiter.sv
// Round-robin uplink arbiter: grants one leaf at a time for up to MAX_BURST
// words, forwarding each through a single output register tagged with its source.
module root_uplink_arbiter #(
  parameter int NUM_LEAVES    = 4,
  parameter int CHANNEL_WIDTH = 64,
  parameter int MAX_BURST     = 4,
  parameter int SRC_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  root_uplink_arbiter_if.master  bus,
  output logic                   busy
);

  localparam int IDX_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [CHANNEL_WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_WIDTH-1:0]     out_src_q, out_src_d;

  logic [IDX_W-1:0]         sel_idx;
  logic                     sel_found;
  logic                     out_free;
  logic                     grant_valid;
  logic                     take;

  // Wrap explicitly at NUM_LEAVES-1 so non-power-of-two leaf counts rotate correctly.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_LEAVES - 1)) ? '0 : i + 1'b1;
  endfunction

  // Round-robin search: first valid leaf starting at ptr, wrapping around.
  always_comb begin
    logic [IDX_W-1:0] idx;
    sel_idx   = ptr_q;
    sel_found = 1'b0;
    idx       = ptr_q;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      if (!sel_found && bus.in_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
      idx = next_idx(idx);
    end
  end

  assign out_free    = !out_valid_q || bus.out_ready;
  assign grant_valid = bus.in_valid[grant_q];
  assign take        = (state_q == GRANT) && grant_valid && out_free;

  // Handshake outputs: only the granted leaf may be popped, and only when the register can accept.
  always_comb begin
    bus.in_ready = '0;
    if (state_q == GRANT) bus.in_ready[grant_q] = out_free;
  end

  assign busy          = (state_q == GRANT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

  // Next-state, burst accounting and output register update.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    // Draining the register frees it unless a new word is loaded the same edge.
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!grant_valid) begin
          // Leaf ran dry: release early, even if the output is stalled.
          state_d = IDLE;
          ptr_d   = next_idx(grant_q);
        end else if (take) begin
          out_data_d  = bus.in_data[CHANNEL_WIDTH*grant_q +: CHANNEL_WIDTH];
          out_src_d   = SRC_WIDTH'(grant_q);
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            ptr_d   = next_idx(grant_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output register; synchronous reset drops any held word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

endmodule

// File: tb/tb_root_uplink_arbiter.sv
// Directed bench for root_uplink_arbiter: leaf FIFOs are modelled as queues,
// output transfers are logged and compared against hand-computed sequences.
module tb_root_uplink_arbiter;

  localparam int NL = 4;
  localparam int W  = 64;

  typedef struct {
    int          cyc;
    logic [3:0]  src;
    logic [63:0] data;
  } rec_t;

  logic clk;
  logic reset;
  logic busy;

  root_uplink_arbiter_if #(.NUM_LEAVES(NL), .CHANNEL_WIDTH(W), .SRC_WIDTH(4)) bus ();

  root_uplink_arbiter #(
    .NUM_LEAVES(NL), .CHANNEL_WIDTH(W), .MAX_BURST(4), .SRC_WIDTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] lq [NL][$];
  rec_t        got[$];
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NL; i++) begin
      bus.in_valid[i]      = (lq[i].size() > 0);
      bus.in_data[W*i +: W] = (lq[i].size() > 0) ? lq[i][0] : 64'h0;
    end
  endtask

  // One clock: sample handshakes mid-cycle, then apply pops after the edge.
  task automatic tick();
    logic [NL-1:0] popped;
    @(negedge clk);
    popped = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready)
      got.push_back('{cyc, bus.out_src, bus.out_data});
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NL; i++)
      if (popped[i] && lq[i].size() > 0) void'(lq[i].pop_front());
    drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic rec_t get(input int k);
    rec_t r;
    r = '{-1, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF};
    if (k < got.size()) r = got[k];
    return r;
  endfunction

  task automatic do_reset();
    for (int i = 0; i < NL; i++) lq[i].delete();
    drive();
    bus.out_ready = 1'b1;
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    got.delete();
  endtask

  initial begin
    rec_t r;
    rec_t r2;
    int   n;
    logic [3:0]  exp_src [8];
    logic [63:0] exp_dat [8];

    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;

    // Reset state
    do_reset();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_out_data",  bus.out_data,       64'd0);
    check("rst_out_src",   64'(bus.out_src),   64'd0);
    check("rst_ptr",       64'(dut.ptr_q),     64'd0);

    // Single leaf: 6 words on leaf 2, burst of 4 then a gap then the rest
    for (int j = 0; j < 6; j++) lq[2].push_back(64'hA0 + 64'(j));
    drive();
    ticks(14);
    check("t1_count", 64'(got.size()), 64'd6);
    for (int j = 0; j < 6; j++) begin
      r = get(j);
      check($sformatf("t1_data%0d", j), r.data, 64'hA0 + 64'(j));
      check($sformatf("t1_src%0d", j), 64'(r.src), 64'd2);
    end
    r = get(0); r2 = get(3);
    check("t1_burst_span", 64'(r2.cyc - r.cyc), 64'd3);
    r = get(4);
    check("t1_gap", 64'(r.cyc - r2.cyc), 64'd2);
    r2 = get(5);
    check("t1_tail", 64'(r2.cyc - r.cyc), 64'd1);
    check("t1_ptr",  64'(dut.ptr_q), 64'd3);
    check("t1_busy", 64'(busy), 64'd0);

    // Fairness: every leaf has two words, ptr=0
    do_reset();
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < 2; j++) lq[i].push_back(64'h100 + 64'(16 * i + j));
    drive();
    ticks(24);
    exp_src = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
    exp_dat = '{64'h100, 64'h101, 64'h110, 64'h111, 64'h120, 64'h121, 64'h130, 64'h131};
    check("t2_count", 64'(got.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      r = get(k);
      check($sformatf("t2_src%0d", k),  64'(r.src), 64'(exp_src[k]));
      check($sformatf("t2_data%0d", k), r.data,     exp_dat[k]);
    end

    // Back-pressure: stall after the first word for 5 cycles
    do_reset();
    for (int j = 0; j < 4; j++) lq[1].push_back(64'hB0 + 64'(j));
    drive();
    n = 0;
    while (got.size() < 1 && n < 50) begin
      tick();
      n++;
    end
    check("t3_first_seen", 64'(got.size()), 64'd1);
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("t3_hold_valid%0d", s), 64'(bus.out_valid), 64'd1);
      check($sformatf("t3_hold_data%0d", s),  bus.out_data,       64'hB1);
      check($sformatf("t3_hold_rdy%0d", s),   64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    ticks(10);
    check("t3_count", 64'(got.size()), 64'd4);
    for (int j = 0; j < 4; j++) begin
      r = get(j);
      check($sformatf("t3_data%0d", j), r.data, 64'hB0 + 64'(j));
    end

    // Wrap-around: bring ptr to 3, then leaves 0 and 3 compete
    do_reset();
    lq[2].push_back(64'hC2);
    drive();
    ticks(6);
    check("t4_ptr_pre", 64'(dut.ptr_q), 64'd3);
    got.delete();
    lq[0].push_back(64'hD0);
    lq[3].push_back(64'hD3);
    drive();
    ticks(10);
    check("t4_count", 64'(got.size()), 64'd2);
    r = get(0);
    check("t4_first_src", 64'(r.src), 64'd3);
    check("t4_first_data", r.data, 64'hD3);
    r = get(1);
    check("t4_second_src", 64'(r.src), 64'd0);
    check("t4_ptr_post", 64'(dut.ptr_q), 64'd1);

    // Early release: leaf 0 runs dry after 2 words, leaf 1 waiting
    do_reset();
    lq[0].push_back(64'hE0);
    lq[0].push_back(64'hE1);
    lq[1].push_back(64'hF0);
    drive();
    n = 0;
    while (lq[0].size() > 0 && n < 50) begin
      tick();
      n++;
    end
    check("t5_leaf0_drained", 64'(lq[0].size()), 64'd0);
    check("t5_busy_before", 64'(busy), 64'd1);
    tick();
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_ptr",  64'(dut.ptr_q), 64'd1);
    tick();
    check("t5_busy_regrant", 64'(busy), 64'd1);
    check("t5_in_ready", 64'(bus.in_ready), 64'b0010);
    ticks(6);
    check("t5_count", 64'(got.size()), 64'd3);
    r = get(2);
    check("t5_last_src", 64'(r.src), 64'd1);
    check("t5_last_data", r.data, 64'hF0);

    // Reset mid-burst: leaves 2 and 3 valid, reset in 3rd grant cycle
    do_reset();
    for (int j = 0; j < 4; j++) begin
      lq[2].push_back(64'h200 + 64'(j));
      lq[3].push_back(64'h300 + 64'(j));
    end
    drive();
    ticks(3);
    check("t6_pre_valid", 64'(bus.out_valid), 64'd1);
    check("t6_pre_busy",  64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_ready", 64'(bus.in_ready), 64'd0);
    check("t6_rst_busy",  64'(busy), 64'd0);
    reset = 1'b0;
    tick();
    check("t6_regrant_busy",  64'(busy), 64'd1);
    check("t6_regrant_ready", 64'(bus.in_ready), 64'b0100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
